// File: rtl/int_mul_issue.sv
// Issue/sequencing stage in front of the multi-cycle unsigned multiplier core (RV64M MUL/MULH/MULHSU/MULHU/MULW).
// Build option INT_MUL_ZERO_BYPASS_EN: ops with a zero operand retire without starting the core.

module int_mul_issue #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [XLEN-1:0]  mul_op1,
    output logic [XLEN-1:0]  mul_op2,
    output logic             mul_sel,
    output logic             mul_start,
    input  logic             mul_ready,
    input  logic [XLEN-1:0]  mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    // state | meaning
    // IDLE  | waiting for an op from dispatch
    // ISSUE | one-cycle start pulse to the core
    // WAIT  | core counting; mul_ready sampled here only
    // DONE  | result held for writeback until out_ready or flush
    // DRAIN | op killed; wait for the core to finish before reuse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    typedef enum logic [2:0] {
        K_MUL,
        K_MULH,
        K_MULHSU,
        K_MULHU,
        K_MULW
    } kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, in_kind;
    logic [XLEN-1:0]   op1_q, op2_q;
    logic [TAG_W-1:0]  tag_q;
    logic              accept;
    logic              zero_op;
    logic              load_result;
    logic [XLEN-1:0]   corr_a, corr_b, fixed_result;

`ifdef INT_MUL_ZERO_BYPASS_EN
    assign zero_op = (in_op1 == '0) || (in_op2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    // MULW wins over funct3; reserved funct3 encodings run as plain MUL
    always_comb begin
        in_kind = K_MUL;
        if (in_word) begin
            in_kind = K_MULW;
        end else begin
            case (in_funct3)
                3'b001:  in_kind = K_MULH;
                3'b010:  in_kind = K_MULHSU;
                3'b011:  in_kind = K_MULHU;
                default: in_kind = K_MUL;
            endcase
        end
    end

    assign accept      = (state_q == S_IDLE) && in_valid && !flush;
    assign load_result = (state_q == S_WAIT) && !flush && mul_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = zero_op ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (mul_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mul_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Core returns an unsigned product half; signed high halves subtract the
    // operand whose partner was negative, all mod 2^XLEN.
    always_comb begin
        corr_a = '0;
        corr_b = '0;
        if (((kind_q == K_MULH) || (kind_q == K_MULHSU)) && op1_q[XLEN-1]) begin
            corr_a = op2_q;
        end
        if ((kind_q == K_MULH) && op2_q[XLEN-1]) begin
            corr_b = op1_q;
        end
        fixed_result = mul_result - corr_a - corr_b;
        if (kind_q == K_MULW) begin
            fixed_result = {{(XLEN/2){mul_result[XLEN/2-1]}}, mul_result[XLEN/2-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q      <= '0;
            op2_q      <= '0;
            tag_q      <= '0;
            kind_q     <= K_MUL;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (accept) begin
                op1_q  <= in_op1;
                op2_q  <= in_op2;
                tag_q  <= in_tag;
                kind_q <= in_kind;
            end
            if (accept && zero_op) begin
                out_result <= '0;
                out_tag    <= in_tag;
            end else if (load_result) begin
                out_result <= fixed_result;
                out_tag    <= tag_q;
            end
        end
    end

    assign mul_op1 = op1_q;
    assign mul_op2 = op2_q;
    assign mul_sel = (kind_q == K_MULH) || (kind_q == K_MULHSU) || (kind_q == K_MULHU);

endmodule

// File: tb/tb_int_mul_issue.sv
// Scoreboard bench for int_mul_issue with a behavioural unsigned multiplier core.
// Expected sel/result/tag values are hand-computed and queued at issue time.

module tb_int_mul_issue;
    localparam int TAG_W = 6;
    localparam int XLEN  = 64;
    localparam int LAT   = 4;
`ifdef INT_MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_word;
    logic [XLEN-1:0]  in_op1, in_op2;
    logic [TAG_W-1:0] in_tag;
    logic [XLEN-1:0]  mul_op1, mul_op2;
    logic             mul_sel, mul_start, mul_ready;
    logic [XLEN-1:0]  mul_result;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    bit   sel_q[$];
    exp_t mon_e;
    int   core_cnt;

    int_mul_issue #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_word(in_word), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_sel(mul_sel),
        .mul_start(mul_start), .mul_ready(mul_ready), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] core_prod(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic sel);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return sel ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    // Behavioural core: ready drops on start, rises LAT cycles later, then holds.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_ready  <= 1'b0;
            mul_result <= '0;
            core_cnt   <= 0;
        end else if (mul_start) begin
            mul_ready  <= 1'b0;
            mul_result <= core_prod(mul_op1, mul_op2, mul_sel);
            core_cnt   <= LAT;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) mul_ready <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mul_start) begin
                if (sel_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got mul_start=1, expected no start");
                end else begin
                    check("mul_sel", mul_sel, sel_q.pop_front());
                end
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got result 0x%h tag %0d, expected none", out_result, out_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_result", out_result, mon_e.res);
                    check("out_tag", out_tag, mon_e.tag);
                end
            end
        end
    end

    task automatic drive_op(input logic [2:0] f3, input logic w, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_word   = w;
        in_op1    = a;
        in_op2    = b;
        in_tag    = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op1   = ~a;
        in_op2   = ~b;
        in_tag   = ~tag;
    endtask

    // Issue one op, check latency, stall `stall` cycles, then deliver (or kill with flush).
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          input logic [XLEN-1:0] exp_res, input int stall, input bit kill);
        bit sel;
        bit byp;
        int cyc;
        sel = !w && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
        byp = BYPASS && (a == '0 || b == '0);
        check("in_ready_idle", in_ready, 1);
        if (!byp) sel_q.push_back(sel);
        if (!kill) exp_q.push_back('{exp_res, tag});
        drive_op(f3, w, a, b, tag);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, byp ? 0 : LAT + 2);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_result", out_result, exp_res);
            check("stall_tag", out_tag, tag);
        end
        out_ready = 1'b1;
        flush     = kill;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        flush     = 1'b0;
        check("valid_drop", out_valid, 0);
        check("back_to_idle", in_ready, 1);
    endtask

    // Accept an op, flush it `n` cycles after the accept edge, then wait out DRAIN.
    task automatic flush_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int n);
        int cyc;
        bit saw_valid;
        sel_q.push_back(1'b0);
        drive_op(3'b000, 1'b0, a, b, 6'd9);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cyc       = 0;
        saw_valid = 1'b0;
        while (!in_ready && cyc < 50) begin
            saw_valid |= out_valid;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_no_valid", saw_valid, 0);
        check("drain_cycles", cyc, LAT + 1 - n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = '0;
        in_word   = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_out_result", out_result, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd5, 64'd1, 0, 0);
        run_op(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 64'd0, 0, 0);
        run_op(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_op(3'b000, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 6'd3, 64'hFFFF_FFFF_8000_0000, 0, 0);
        run_op(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_op(3'b000, 1'b1, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0005, 6'd6, 64'd15, 0, 0);

        // back-to-back with a 3-cycle writeback stall, then a reserved funct3
        run_op(3'b000, 1'b0, 64'd3, 64'd5, 6'd7, 64'd15, 3, 0);
        run_op(3'b100, 1'b0, 64'd6, 64'd7, 6'd8, 64'd42, 0, 0);

        // flush in IDLE blocks acceptance
        in_valid = 1'b1;
        in_op1   = 64'd2;
        in_op2   = 64'd2;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_no_accept", in_ready, 1);

        flush_op(64'd11, 64'd13, 2);
        run_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'd10, 64'd2, 0, 0);
        flush_op(64'd17, 64'd19, 0);

        // flush wins over out_ready in DONE
        run_op(3'b000, 1'b0, 64'd21, 64'd2, 6'd11, 64'd42, 1, 1);
        run_op(3'b000, 1'b0, 64'd0, 64'd7, 6'd12, 64'd0, 0, 0);

        // async reset in the middle of WAIT
        sel_q.push_back(1'b1);
        drive_op(3'b011, 1'b0, 64'h8000_0000_0000_0001, 64'd9, 6'd13);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_result", out_result, 0);
        check("rst_mid_out_tag", out_tag, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_mul_sel", mul_sel, 0);
        check("rst_mid_mul_op1", mul_op1, 0);
        check("rst_mid_mul_op2", mul_op2, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(3'b000, 1'b0, 64'd100, 64'd100, 6'd14, 64'd10000, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_empty", exp_q.size(), 0);
        check("sel_queue_empty", sel_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
